// File: rtl/top.sv
// top: registered 2-input logic functions; `define TOP_SWITCH_LEVEL_EN for a CMOS switch-level gate build
`ifdef TOP_SWITCH_LEVEL_EN
module top_inv (
  output wire o,
  input  wire a
);
  supply1 vdd;
  supply0 gnd;
  pmos p0 (o, vdd, a);
  nmos n0 (o, gnd, a);
endmodule

module top_nand (
  output wire o,
  input  wire a,
  input  wire b
);
  supply1 vdd;
  supply0 gnd;
  wire m;
  pmos p0 (o, vdd, a);
  pmos p1 (o, vdd, b);
  nmos n0 (o, m, a);
  nmos n1 (m, gnd, b);
endmodule

module top_nor (
  output wire o,
  input  wire a,
  input  wire b
);
  supply1 vdd;
  supply0 gnd;
  wire m;
  pmos p0 (m, vdd, a);
  pmos p1 (o, m, b);
  nmos n0 (o, gnd, a);
  nmos n1 (o, gnd, b);
endmodule
`endif

module top (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  output logic not_x,
  output logic nand_out,
  output logic nor_out,
  output logic and_out,
  output logic or_out,
  output logic xor_out,
  output logic xnor_out
);
`ifdef TOP_SWITCH_LEVEL_EN
  wire nx, nd, nr, an, orr, xo, xn, xa, xb;
  top_inv  u_nx  (.o(nx),  .a(x));
  top_nand u_nd  (.o(nd),  .a(x),  .b(y));
  top_nor  u_nr  (.o(nr),  .a(x),  .b(y));
  top_inv  u_an  (.o(an),  .a(nd));
  top_inv  u_or  (.o(orr), .a(nr));
  top_nand u_xa  (.o(xa),  .a(x),  .b(nd));
  top_nand u_xb  (.o(xb),  .a(y),  .b(nd));
  top_nand u_xo  (.o(xo),  .a(xa), .b(xb));
  top_inv  u_xn  (.o(xn),  .a(xo));
`else
  logic nx, nd, nr, an, orr, xo, xn;
  assign nx  = ~x;
  assign nd  = ~(x & y);
  assign nr  = ~(x | y);
  assign an  = x & y;
  assign orr = x | y;
  assign xo  = x ^ y;
  assign xn  = ~(x ^ y);
`endif
  logic [6:0] q;
  // capture all seven functions from the same edge; reset clears them asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= {nx, nd, nr, an, orr, xo, xn};
  assign {not_x, nand_out, nor_out, and_out, or_out, xor_out, xnor_out} = q;
endmodule

// File: tb/tb_top.sv
// tb_top: randomized self-checking bench for top against a truth-table reference model
module tb_top;
  logic clk = 0, rst = 1, x = 1, y = 1;
  logic not_x, nand_out, nor_out, and_out, or_out, xor_out, xnor_out;
  logic [6:0] out, tbl [4];
  int compared = 0, mismatched = 0;

  top dut (.clk(clk), .rst(rst), .x(x), .y(y), .not_x(not_x), .nand_out(nand_out),
           .nor_out(nor_out), .and_out(and_out), .or_out(or_out), .xor_out(xor_out),
           .xnor_out(xnor_out));

  assign out = {not_x, nand_out, nor_out, and_out, or_out, xor_out, xnor_out};
  always #5 clk = ~clk;

  task automatic step(input logic [1:0] v, input string name);
    {x, y} = v;
    @(posedge clk);
    #1;
    compared++;
    if (out !== tbl[v]) begin
      mismatched++;
      $display("FAIL %s xy=%b: got %b expected %b", name, v, out, tbl[v]);
    end
    compared++;
    if (nand_out !== ~and_out || nor_out !== ~or_out || xnor_out !== ~xor_out) begin
      mismatched++;
      $display("FAIL %s_invariant xy=%b: got %b", name, v, out);
    end
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (out !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_async: got %b expected 0000000", out);
    end
    @(posedge clk);
    #1;
    compared++;
    if (out !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_hold: got %b expected 0000000", out);
    end
    rst = 0;
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 4; i++) step(2'(i), "truth_row");
    step(2'(4), "wrap_row00");
  endtask

  task automatic test_mid_cycle();
    step(2'b01, "mid_load");
    for (int i = 0; i < 3; i++) begin
      #1 {x, y} = 2'($urandom_range(0, 3));
      compared++;
      if (out !== tbl[1]) begin
        mismatched++;
        $display("FAIL mid_cycle_hold: got %b expected %b", out, tbl[1]);
      end
    end
    step(2'b10, "mid_next");
  endtask

  task automatic test_mid_reset();
    step(2'b11, "mreset_load");
    #2 rst = 1;
    #1;
    compared++;
    if (out !== 7'b0) begin
      mismatched++;
      $display("FAIL mid_reset_async: got %b expected 0000000", out);
    end
    @(posedge clk);
    #2 rst = 0;
    step(2'b10, "mreset_release");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) step(2'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    tbl[0] = 7'b1110001;
    tbl[1] = 7'b1100110;
    tbl[2] = 7'b0100110;
    tbl[3] = 7'b0001101;
    test_reset();
    test_truth_table();
    test_mid_cycle();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
